// File: rtl/slot_pkg.sv
// Shared definitions for the slot machine controller: FSM state encoding,
// LFSR seed/taps and the winning reel values.
package slot_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SPIN   = 2'd1;
  localparam state_t ST_EVAL   = 2'd2;
  localparam state_t ST_PAYOUT = 2'd3;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 counted from 1, i.e. bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  localparam logic [2:0] WIN_VALUE      = 3'b111;
  localparam logic [2:0] ALT_WIN_VALUE  = 3'b101;
  localparam logic [3:0] ALT_WIN_PAYOUT = 4'd1;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/slot_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used as the reel source; reseeds on reset.
module slot_lfsr
  import slot_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] value
);

  logic [7:0] value_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      value_reg <= LFSR_SEED;
    end else begin
      value_reg <= lfsr_next(value_reg);
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/slot_controller.sv
// Slot machine controller: credit counter, lever-triggered spin FSM and
// payout handshake. Optional macro SLOT_ALT_WIN_EN adds 3'b101 as a second win.
module slot_controller
  import slot_pkg::*;
#(
  parameter int SPIN_CYCLES = 16,
  parameter int MAX_CREDITS = 255,
  parameter int WIN_PAYOUT  = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin,
  input  logic       lever,
  input  logic       payout_ack,
  output logic [2:0] display,
  output logic [7:0] credits,
  output logic       busy,
  output logic       payout_req,
  output logic [3:0] payout_amt,
  output logic       no_credit
);

  localparam logic [7:0] SPIN_LOAD = 8'(SPIN_CYCLES - 1);
  localparam logic [7:0] MAX_C     = 8'(MAX_CREDITS);
  localparam logic [3:0] WIN_AMT   = 4'(WIN_PAYOUT);

  logic [7:0] lfsr_value;
  logic       lfsr_unused;

  state_t     state_reg, state_next;
  logic [7:0] spin_cnt_reg, spin_cnt_next;
  logic [2:0] result_reg, result_next;
  logic [2:0] display_reg, display_next;
  logic [7:0] credits_reg, credits_next;
  logic       busy_reg, busy_next;
  logic       payout_req_reg, payout_req_next;
  logic [3:0] payout_amt_reg, payout_amt_next;
  logic       no_credit_reg, no_credit_next;
  logic       lever_q;

  logic       lever_edge;
  logic       start_spin;
  logic       is_win;
  logic [3:0] win_amt;

  slot_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr_value)
  );

  // Only the low three bits drive the reel.
  assign lfsr_unused = ^lfsr_value[7:3];

  assign lever_edge = lever & ~lever_q;
  assign start_spin = (state_reg == ST_IDLE) && lever_edge && (credits_reg != 8'd0);

  always_comb begin
    is_win  = 1'b0;
    win_amt = 4'd0;
    if (result_reg == WIN_VALUE) begin
      is_win  = 1'b1;
      win_amt = WIN_AMT;
    end
`ifdef SLOT_ALT_WIN_EN
    else if (result_reg == ALT_WIN_VALUE) begin
      is_win  = 1'b1;
      win_amt = ALT_WIN_PAYOUT;
    end
`endif
  end

  // A coin landing in the same cycle as a spin debit cancels out, even at saturation.
  always_comb begin
    credits_next = credits_reg;
    if (start_spin && !coin) begin
      credits_next = credits_reg - 8'd1;
    end else if (coin && !start_spin && (credits_reg < MAX_C)) begin
      credits_next = credits_reg + 8'd1;
    end
  end

  always_comb begin
    state_next      = state_reg;
    spin_cnt_next   = spin_cnt_reg;
    result_next     = result_reg;
    display_next    = display_reg;
    busy_next       = busy_reg;
    payout_req_next = payout_req_reg;
    payout_amt_next = payout_amt_reg;
    no_credit_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        display_next = 3'b000;
        if (lever_edge) begin
          if (credits_reg != 8'd0) begin
            state_next    = ST_SPIN;
            spin_cnt_next = SPIN_LOAD;
            busy_next     = 1'b1;
          end else begin
            no_credit_next = 1'b1;
          end
        end
      end

      ST_SPIN: begin
        display_next = lfsr_value[2:0];
        if (spin_cnt_reg == 8'd0) begin
          result_next = lfsr_value[2:0];
          state_next  = ST_EVAL;
        end else begin
          spin_cnt_next = spin_cnt_reg - 8'd1;
        end
      end

      ST_EVAL: begin
        if (is_win) begin
          state_next      = ST_PAYOUT;
          payout_req_next = 1'b1;
          payout_amt_next = win_amt;
          display_next    = WIN_VALUE;
        end else begin
          state_next   = ST_IDLE;
          busy_next    = 1'b0;
          display_next = 3'b000;
        end
      end

      ST_PAYOUT: begin
        display_next = WIN_VALUE;
        if (payout_ack) begin
          state_next      = ST_IDLE;
          payout_req_next = 1'b0;
          payout_amt_next = 4'd0;
          busy_next       = 1'b0;
          display_next    = 3'b000;
        end
      end

      default: begin
        state_next      = ST_IDLE;
        busy_next       = 1'b0;
        payout_req_next = 1'b0;
        payout_amt_next = 4'd0;
        display_next    = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      spin_cnt_reg   <= 8'd0;
      result_reg     <= 3'd0;
      display_reg    <= 3'd0;
      credits_reg    <= 8'd0;
      busy_reg       <= 1'b0;
      payout_req_reg <= 1'b0;
      payout_amt_reg <= 4'd0;
      no_credit_reg  <= 1'b0;
      lever_q        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      spin_cnt_reg   <= spin_cnt_next;
      result_reg     <= result_next;
      display_reg    <= display_next;
      credits_reg    <= credits_next;
      busy_reg       <= busy_next;
      payout_req_reg <= payout_req_next;
      payout_amt_reg <= payout_amt_next;
      no_credit_reg  <= no_credit_next;
      lever_q        <= lever;
    end
  end

  assign display    = display_reg;
  assign credits    = credits_reg;
  assign busy       = busy_reg;
  assign payout_req = payout_req_reg;
  assign payout_amt = payout_amt_reg;
  assign no_credit  = no_credit_reg;

endmodule
